l2_victim_select: RTL and testbench

- Stage directly downstream of the L2 tag/state lookup.
- Consumes the registered lookup result (hit way, empty way, per-set eviction pointer) and decides which way the current request will use: the hit way, an empty way, or a victim way.
- Round-robin victim search skips ways locked by in-flight transactions.
- Holds the decision until the L2 controller accepts it, then returns the updated eviction pointer for write-back to the evict-way array.

---
 rtl/l2_victim_select_pkg.sv | 23 ++
 rtl/l2_victim_select.sv | 113 +++++++++++
 tb/tb_l2_victim_select.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/l2_victim_select_pkg.sv
// Shared types for the L2 victim-selection stage: decision kinds, FSM states
// and the default way-index type.
package l2_victim_select_pkg;

  localparam int L2_WAYS_DEFAULT = 8;
  localparam int WAY_BITS_DEFAULT = $clog2(L2_WAYS_DEFAULT);

  typedef logic [WAY_BITS_DEFAULT-1:0] l2_way_t;

  typedef enum logic [1:0] {
    SEL_HIT      = 2'd0,
    SEL_FILL     = 2'd1,
    SEL_EVICT    = 2'd2,
    SEL_SET_BUSY = 2'd3
  } l2_sel_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } l2_vs_state_t;

endpackage

// File: rtl/l2_victim_select.sv
// Picks the way a request uses after L2 tag lookup (hit, empty fill, or round-robin
// victim skipping locked ways); holds the decision until accepted, then returns the new pointer.
module l2_victim_select
  import l2_victim_select_pkg::*;
#(
  parameter int L2_WAYS  = 8,
  parameter int WAY_BITS = $clog2(L2_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                lookup_done,
  input  logic                tag_hit,
  input  logic [WAY_BITS-1:0] way_hit,
  input  logic                empty_way_found,
  input  logic [WAY_BITS-1:0] empty_way,
  input  logic [WAY_BITS-1:0] evict_way_buf,
  input  logic [L2_WAYS-1:0]  way_locked,
  output logic                busy,
  output logic                sel_valid,
  input  logic                sel_ready,
  output logic [WAY_BITS-1:0] sel_way,
  output logic [1:0]          sel_kind,
  output logic                evict_upd_valid,
  output logic [WAY_BITS-1:0] evict_upd_way
);

  localparam logic [WAY_BITS-1:0] LAST_CNT = WAY_BITS'(L2_WAYS - 1);
  localparam logic [WAY_BITS-1:0] ONE      = WAY_BITS'(1);

  l2_vs_state_t        state;
  l2_sel_kind_t        kind_q;
  logic [WAY_BITS-1:0] cand;
  logic [WAY_BITS-1:0] scan_cnt;
  // Pointer captured at lookup; SET_BUSY reports it even if the input moves on.
  logic [WAY_BITS-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      kind_q    <= SEL_HIT;
      cand      <= '0;
      scan_cnt  <= '0;
      ptr_q     <= '0;
      sel_way   <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lookup_done) begin
            busy <= 1'b1;
            if (tag_hit) begin
              sel_way   <= way_hit;
              kind_q    <= SEL_HIT;
              sel_valid <= 1'b1;
              state     <= ST_HOLD;
            end else if (empty_way_found) begin
              sel_way   <= empty_way;
              kind_q    <= SEL_FILL;
              sel_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              cand     <= evict_way_buf;
              ptr_q    <= evict_way_buf;
              scan_cnt <= '0;
              state    <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (!way_locked[cand]) begin
            sel_way   <= cand;
            kind_q    <= SEL_EVICT;
            sel_valid <= 1'b1;
            state     <= ST_HOLD;
          end else if (scan_cnt == LAST_CNT) begin
            sel_way   <= ptr_q;
            kind_q    <= SEL_SET_BUSY;
            sel_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            cand     <= cand + ONE;
            scan_cnt <= scan_cnt + ONE;
          end
        end
        ST_HOLD: begin
          if (sel_ready) begin
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          sel_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_kind = kind_q;

  // The pointer write-back must coincide with the accepting handshake, so it is decoded live.
  assign evict_upd_valid = (state == ST_HOLD) && sel_ready && !clear && (kind_q == SEL_EVICT);
  assign evict_upd_way   = evict_upd_valid ? (sel_way + ONE) : '0;

endmodule

// File: tb/tb_l2_victim_select.sv
// Randomized bench for l2_victim_select with a transaction-level reference model.
module tb_l2_victim_select;

  localparam int N  = 8;
  localparam int WB = 3;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          lookup_done;
  logic          tag_hit;
  logic [WB-1:0] way_hit;
  logic          empty_way_found;
  logic [WB-1:0] empty_way;
  logic [WB-1:0] evict_way_buf;
  logic [N-1:0]  way_locked;
  logic          busy;
  logic          sel_valid;
  logic          sel_ready;
  logic [WB-1:0] sel_way;
  logic [1:0]    sel_kind;
  logic          evict_upd_valid;
  logic [WB-1:0] evict_upd_way;

  int n_chk  = 0;
  int n_pass = 0;

  logic [N-1:0] locks [N];

  l2_victim_select #(.L2_WAYS(N), .WAY_BITS(WB)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .lookup_done(lookup_done), .tag_hit(tag_hit), .way_hit(way_hit),
    .empty_way_found(empty_way_found), .empty_way(empty_way),
    .evict_way_buf(evict_way_buf), .way_locked(way_locked),
    .busy(busy), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_way(sel_way), .sel_kind(sel_kind),
    .evict_upd_valid(evict_upd_valid), .evict_upd_way(evict_upd_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decision kind/way and cycles from lookup_done to sel_valid.
  task automatic model(input bit th, input int wh, input bit ef, input int ew, input int bf,
                       output int kind, output int way, output int lat);
    if (th) begin
      kind = 0; way = wh; lat = 1;
    end else if (ef) begin
      kind = 1; way = ew; lat = 1;
    end else begin
      kind = 3; way = bf; lat = N + 1;
      for (int k = 0; k < N; k++) begin
        if (!locks[k][(bf + k) % N]) begin
          kind = 2; way = (bf + k) % N; lat = k + 2;
          break;
        end
      end
    end
  endtask

  task automatic run_txn(input bit th, input int wh, input bit ef, input int ew, input int bf,
                         input int hold, input bit clr, input bit noise);
    int ekind, eway, elat, lat;
    model(th, wh, ef, ew, bf, ekind, eway, elat);
    lookup_done     = 1'b1;
    tag_hit         = th;
    way_hit         = WB'(wh);
    empty_way_found = ef;
    empty_way       = WB'(ew);
    evict_way_buf   = WB'(bf);
    sel_ready       = 1'b0;
    step();
    lookup_done = 1'b0;
    lat = 1;
    way_locked = locks[0];
    #1;
    while (!sel_valid && lat < 30) begin
      chk("busy_scan", busy, 1);
      step();
      lat++;
      way_locked = (lat - 1 < N) ? locks[lat - 1] : N'($urandom);
      if (noise) begin
        lookup_done     = 1'($urandom_range(0, 1));
        tag_hit         = 1'($urandom_range(0, 1));
        empty_way_found = 1'($urandom_range(0, 1));
        evict_way_buf   = WB'($urandom);
      end
      #1;
    end
    lookup_done = 1'b0;
    chk("latency", lat, elat);
    chk("kind", sel_kind, ekind);
    chk("way", sel_way, eway);
    for (int h = 0; h < hold; h++) begin
      step();
      way_locked = N'($urandom);
      #1;
      chk("hold_valid", sel_valid, 1);
      chk("hold_kind", sel_kind, ekind);
      chk("hold_way", sel_way, eway);
      chk("hold_upd", evict_upd_valid, 0);
    end
    chk("busy_hold", busy, 1);
    sel_ready = 1'b1;
    clear     = clr;
    #1;
    chk("upd_valid", evict_upd_valid, (ekind == 2 && !clr) ? 1 : 0);
    if (ekind == 2 && !clr) chk("upd_way", evict_upd_way, (eway + 1) % N);
    step();
    sel_ready = 1'b0;
    clear     = 1'b0;
    #1;
    chk("post_valid", sel_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_upd", evict_upd_valid, 0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; lookup_done = 1'b0; tag_hit = 1'b0; way_hit = '0;
    empty_way_found = 1'b0; empty_way = '0; evict_way_buf = '0; way_locked = '0;
    sel_ready = 1'b0;
    #12;
    chk("rst_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_way", sel_way, 0);
    chk("rst_kind", sel_kind, 0);
    chk("rst_upd", evict_upd_valid, 0);
    chk("rst_upd_way", evict_upd_way, 0);
    rst = 1'b1;
    step();

    for (int k = 0; k < N; k++) locks[k] = '0;
    run_txn(1, 5, 1, 2, 0, 0, 0, 0);
    run_txn(0, 0, 1, 3, 0, 4, 0, 0);
    for (int k = 0; k < N; k++) locks[k] = 8'b0100_0000;
    run_txn(0, 0, 0, 0, 6, 1, 0, 0);
    for (int k = 0; k < N; k++) locks[k] = 8'hFF;
    run_txn(0, 0, 0, 0, 2, 0, 0, 0);
    for (int k = 0; k < N; k++) locks[k] = 8'b0001_1000;
    run_txn(0, 0, 0, 0, 3, 1, 1, 1);

    for (int t = 0; t < 200; t++) begin
      int mode;
      mode = $urandom_range(0, 9);
      for (int k = 0; k < N; k++)
        locks[k] = (mode == 9) ? 8'hFF : N'($urandom & $urandom & ((mode > 6) ? 32'hFF : $urandom));
      run_txn(mode == 0 || mode == 1, $urandom_range(0, N - 1), mode == 2 || mode == 1,
              $urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while a decision is held.
    lookup_done = 1'b1; tag_hit = 1'b1; way_hit = 3'd6;
    step();
    lookup_done = 1'b0;
    #1;
    chk("pre_arst_valid", sel_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", sel_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_way", sel_way, 0);
    chk("arst_kind", sel_kind, 0);
    step();
    rst = 1'b1;
    step();
    #1;
    chk("arst_idle_valid", sel_valid, 0);
    chk("arst_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
